// File: rtl/piano_keys_pkg.sv
// Shared constants and types for the pushbutton front end.
package piano_keys_pkg;

    // Number of pushbutton channels on the board.
    localparam int NUM_KEYS                = 4;

    // System clock frequency in Hz.
    localparam int CLK_HZ                  = 50_000_000;

    // 10 ms qualification window at CLK_HZ.
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;

    // Per-channel debounce FSM states.
    // STABLE means the output agrees with the sample.
    // QUALIFY means a disagreement is being counted.
    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } dbn_state_t;

endpackage : piano_keys_pkg

// File: rtl/key_debounce_cell.sv
// One debounce channel.
// It has a two-flop synchronizer, polarity normalisation and a counting
// STABLE/QUALIFY FSM. The FSM drives a registered clean level and a
// registered busy flag.
module key_debounce_cell
    import piano_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_key,
    output logic o_clean,
    output logic o_busy
);

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter cannot wrap.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // This count is the last one before the mismatch tally reaches DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level of a released button.
    localparam logic             PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    // With a one-cycle window the first mismatch already qualifies.
    localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    logic             r_sync1;
    logic             r_sync2;
    dbn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_busy;

    logic             w_sample;
    logic             w_mismatch;
    dbn_state_t       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_clean_next;

    // Two-flop synchronizer for the asynchronous pin. It rests at the released level.
    // NOTE: non-blocking assignments let r_sync2 take the old r_sync1, so this really is two stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= PIN_IDLE;
            r_sync2 <= PIN_IDLE;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // XOR with the idle level turns the synchronized pin into an active-high sample.
    assign w_sample   = r_sync2 ^ PIN_IDLE;
    assign w_mismatch = (w_sample != r_clean);

    // Next-state logic: count consecutive disagreements, and reject any gap.
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_clean_next = r_clean;
        case (r_state)
            STABLE: begin
                if (w_mismatch) begin
                    if (ONE_SHOT) begin
                        w_clean_next = w_sample;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_state_next = QUALIFY;
                        w_cnt_next   = CNT_ONE;
                    end
                end else begin
                    w_cnt_next = CNT_ZERO;
                end
            end
            QUALIFY: begin
                if (!w_mismatch) begin
                    // Glitch reject: the sample went back before the window expired.
                    w_state_next = STABLE;
                    w_cnt_next   = CNT_ZERO;
                end else if (r_cnt >= CNT_LAST) begin
                    // This edge is mismatch number DEBOUNCE_CYCLES, so commit the change.
                    w_clean_next = w_sample;
                    w_state_next = STABLE;
                    w_cnt_next   = CNT_ZERO;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = STABLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Channel state registers.
    // Busy is registered from the next count, so it always equals (r_cnt != 0).
    // NOTE: every flop here has an async reset, so a reset mid-qualification drops the pending change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= STABLE;
            r_cnt   <= CNT_ZERO;
            r_clean <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_clean <= w_clean_next;
            r_busy  <= (w_cnt_next != CNT_ZERO);
        end
    end

    assign o_clean = r_clean;
    assign o_busy  = r_busy;

endmodule : key_debounce_cell

// File: rtl/key_debouncer.sv
// Debouncer for a bank of pushbuttons.
// It uses one independent key_debounce_cell per channel.
// key_clean feeds the press/hold/release edge detector downstream.
module key_debouncer #(
    parameter int NUM_KEYS        = piano_keys_pkg::NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = piano_keys_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_busy
);

    // One channel per key. No state is shared, so the keys never interact.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_cell (
            .clk     (clk),
            .resetn  (resetn),
            .i_key   (KEY[g]),
            .o_clean (key_clean[g]),
            .o_busy  (key_busy[g])
        );
    end

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer.
// Instance a uses a 4-cycle window and instance b a 1-cycle window; both are active-low.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] key_a;
    logic [3:0] key_b;
    logic [3:0] clean_a;
    logic [3:0] busy_a;
    logic [3:0] clean_b;
    logic [3:0] busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    key_debouncer #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut_a (
        .clk       (clk),
        .resetn    (resetn),
        .KEY       (key_a),
        .key_clean (clean_a),
        .key_busy  (busy_a)
    );

    key_debouncer #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1)
    ) dut_b (
        .clk       (clk),
        .resetn    (resetn),
        .KEY       (key_b),
        .key_clean (clean_b),
        .key_busy  (busy_b)
    );

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        key_a  = 4'hF;
        key_b  = 4'hF;

        // Reset state.
        step(3);
        check("rst_clean_a", clean_a, 4'b0000);
        check("rst_busy_a",  busy_a,  4'b0000);
        check("rst_clean_b", clean_b, 4'b0000);
        check("rst_busy_b",  busy_b,  4'b0000);
        resetn = 1'b1;
        step(3);
        check("idle_clean_a", clean_a, 4'b0000);
        check("idle_busy_a",  busy_a,  4'b0000);

        // KEY[0] press: busy on edges 3..5, clean rises on edge 6.
        key_a[0] = 1'b0;
        step(2);
        check("k0_e2_busy",  busy_a,  4'b0000);
        check("k0_e2_clean", clean_a, 4'b0000);
        for (int e = 3; e <= 5; e++) begin
            step(1);
            check("k0_qual_busy",  busy_a,  4'b0001);
            check("k0_qual_clean", clean_a, 4'b0000);
        end
        step(1);
        check("k0_e6_clean", clean_a, 4'b0001);
        check("k0_e6_busy",  busy_a,  4'b0000);
        // Release: falls on edge 6 after the change.
        key_a[0] = 1'b1;
        step(5);
        check("k0_rel_e5_clean", clean_a, 4'b0001);
        check("k0_rel_e5_busy",  busy_a,  4'b0001);
        step(1);
        check("k0_rel_e6_clean", clean_a, 4'b0000);

        // KEY[1] bounces every 2 cycles for 20 cycles, then rests released.
        for (int p = 0; p < 10; p++) begin
            key_a[1] = (p % 2 == 1);
            for (int c = 0; c < 2; c++) begin
                step(1);
                check("k1_bounce_clean", clean_a, 4'b0000);
            end
        end
        step(4);
        check("k1_after_clean", clean_a, 4'b0000);
        check("k1_after_busy",  busy_a,  4'b0000);

        // KEY[2] low for 3 cycles: rejected.
        key_a[2] = 1'b0;
        step(3);
        key_a[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1);
            check("k2_short_clean", clean_a, 4'b0000);
        end
        check("k2_short_busy", busy_a, 4'b0000);

        // KEY[2] low for 4 cycles: clean high on edges 6..9 and low again on edge 10.
        key_a[2] = 1'b0;
        step(4);
        key_a[2] = 1'b1;
        step(1);
        check("k2_e5_clean", clean_a, 4'b0000);
        step(1);
        check("k2_e6_clean", clean_a, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("k2_pulse_clean", clean_a, 4'b0100);
        end
        step(1);
        check("k2_e10_clean", clean_a, 4'b0000);

        // All four keys fall together.
        key_a = 4'b0000;
        step(5);
        check("all_e5_clean", clean_a, 4'b0000);
        check("all_e5_busy",  busy_a,  4'b1111);
        step(1);
        check("all_e6_clean", clean_a, 4'b1111);
        check("all_e6_busy",  busy_a,  4'b0000);
        key_a = 4'hF;
        step(6);
        check("all_rel_clean", clean_a, 4'b0000);

        // Reset in mid-qualification on KEY[3] while KEY[0] is reported pressed.
        key_a = 4'b1110;
        step(6);
        check("pre_rst_clean", clean_a, 4'b0001);
        key_a = 4'b0110;
        step(4);
        check("mid_qual_busy",  busy_a,  4'b1000);
        check("mid_qual_clean", clean_a, 4'b0001);
        resetn = 1'b0;
        #1;
        check("async_rst_clean", clean_a, 4'b0000);
        check("async_rst_busy",  busy_a,  4'b0000);
        step(2);
        check("in_rst_clean", clean_a, 4'b0000);
        resetn = 1'b1;
        step(5);
        check("post_rst_e5_clean", clean_a, 4'b0000);
        step(1);
        check("post_rst_e6_clean", clean_a, 4'b1001);
        key_a = 4'hF;
        step(6);
        check("post_rst_rel_clean", clean_a, 4'b0000);

        // One-cycle window: KEY[0] reported pressed after 3 edges.
        key_b[0] = 1'b0;
        step(2);
        check("d1_e2_clean", clean_b, 4'b0000);
        step(1);
        check("d1_e3_clean", clean_b, 4'b0001);
        check("d1_e3_busy",  busy_b,  4'b0000);
        check("d1_other_dut", clean_a, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_key_debouncer

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive disagreeing samples required before the output changes. Legal range is at least 1.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, the raw pins read 0 while a button is pressed.
REQ-004 Port clk, input, 1 bit: the single clock. All state SHALL update on its rising edge.
REQ-005 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port KEY, input, NUM_KEYS bits: raw pushbutton pins. They are asynchronous to clk and bouncy.
REQ-007 Port key_clean, output, NUM_KEYS bits: debounced level, active-high (1 = pressed). It is registered, and it is the direct KEY input of the downstream press/hold/release edge detector.
REQ-008 Port key_busy, output, NUM_KEYS bits: 1 while a channel's counter is non-zero, that is, while a change is being qualified.

Function
REQ-009 Each KEY bit SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-010 The synchronizer output SHALL be inverted when ACTIVE_LOW=1, giving an active-high sample s[i].
REQ-011 Each channel SHALL hold a counter cnt[i] of width $clog2(DEBOUNCE_CYCLES+1).
REQ-012 Each channel SHALL implement a two-state FSM with states STABLE and QUALIFY.
REQ-013 STABLE: if s[i]==key_clean[i], cnt stays at 0. If they differ, the channel goes to QUALIFY and cnt becomes 1.
REQ-014 QUALIFY, with s[i]==key_clean[i]: the channel returns to STABLE, cnt becomes 0 and key_clean is unchanged. This is a glitch reject.
REQ-015 QUALIFY, with s[i]!=key_clean[i] and cnt < DEBOUNCE_CYCLES: cnt increments.
REQ-016 When the mismatch count reaches DEBOUNCE_CYCLES, key_clean[i] SHALL take the value of s[i] on that same edge, cnt becomes 0 and the channel returns to STABLE.
REQ-017 With DEBOUNCE_CYCLES=1, key_clean[i] SHALL update on the first mismatching edge, and QUALIFY is never occupied for more than zero cycles.
REQ-018 Latency: a clean level change on KEY[i] SHALL be visible on key_clean[i] DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level. That edge count includes the two synchronizer edges.
REQ-019 The counter SHALL never wrap. It SHALL never exceed DEBOUNCE_CYCLES.
REQ-020 Channels SHALL be fully independent. Simultaneous activity on any combination of keys SHALL give per-channel results identical to each key acting alone.
REQ-021 key_clean SHALL change at most once per DEBOUNCE_CYCLES cycles per channel.
REQ-022 key_busy[i] SHALL be a registered function of cnt[i]!=0.

Reset
REQ-023 While resetn=0, the synchronizer flops SHALL hold the "released" pin level (1 when ACTIVE_LOW=1).
REQ-024 While resetn=0, key_clean=0, key_busy=0, cnt=0 and every FSM SHALL be in STABLE.
REQ-025 Reset SHALL assert asynchronously. Its deassertion is synchronous to clk by the system.
REQ-026 Reset asserted mid-qualification SHALL abandon the pending change, with no output pulse.
REQ-027 A button held through reset release SHALL be reported pressed DEBOUNCE_CYCLES+2 edges after release.

Structure
REQ-028 Shared package piano_keys_pkg SHALL hold NUM_KEYS, the DEBOUNCE_CYCLES default, CLK_HZ, and the FSM state enum (STABLE, QUALIFY).
REQ-029 One sub-module, key_debounce_cell, SHALL contain one channel's synchronizer, counter and FSM. key_debouncer SHALL instantiate it NUM_KEYS times.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-030 KEY[0] 1→0, held steady -> key_clean[0] rises on edge 6 after sampling, key_busy[0]=1 for 3 cycles before that, other bits stay 0.
REQ-031 KEY[1] toggles 0/1/0/1 every 2 cycles for 20 cycles then stays 1 -> key_clean[1] never changes.
REQ-032 KEY[2] low for exactly 3 cycles -> key_clean[2] stays 0. Low for exactly 4 cycles -> key_clean[2] pulses high for exactly 4 cycles, then falls.
REQ-033 All four KEY bits fall on the same edge -> key_clean=4'b1111 on the same edge, 6 edges later.
REQ-034 KEY[3] low, resetn pulsed low at cnt=2 -> key_clean[3]=0 immediately, then rises 6 edges after reset release.
REQ-035 DEBOUNCE_CYCLES=1 build, KEY[0] falls -> key_clean[0]=1 after 3 edges.
